frame_encoder: RTL and testbench
================================

Name: frame_encoder

Overview:
Builds and transmits 6-byte command frames (START, 'M', opcode, argument, checksum, STOP) toward the UART transmitter. It uses the same frame format and checksum rule as the command frame decoder on the receive path. A host-side request selects one of two frame types: "MCT" query, or "MD" time-set carrying one data byte. Bytes go to the UART TX over a valid/ready handshake, one byte per accept.

Parameters:
START_BYTE  8'hAA  frame start marker
STOP_BYTE   8'h55  frame stop marker
CHAR_M      8'd77  'M' header byte
CHAR_C      8'd67  'C' opcode (query frame)
CHAR_D      8'd68  'D' opcode (time-set frame)
CHAR_T      8'd84  'T' argument byte of query frame
GAP_CYCLES  0      idle cycles inserted between accepted byte and next tx_valid (0 = back-to-back)

Ports:
clk         in   1  system clock, all logic on rising edge
rst         in   1  asynchronous reset, active-high
req_valid   in   1  frame request
req_ready   out  1  encoder can accept a request (high only in IDLE)
req_type    in   1  0 = MCT query frame, 1 = MD time-set frame
req_data    in   8  time value for MD frame; ignored for MCT
tx_data     out  8  byte to UART TX
tx_valid    out  1  tx_data is valid
tx_ready    in   1  UART TX accepts byte this cycle
busy        out  1  frame in progress (not IDLE)
frame_done  out  1  one-cycle pulse after STOP byte accepted

Behaviour:
- Reset (async, asserts immediately): state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, req_ready=1, index=0, sum=START_BYTE+STOP_BYTE (8'hFF).
- Request accept: req_valid && req_ready in cycle N. Latch req_type/req_data, set index=0, set sum=START_BYTE+STOP_BYTE. Go to SEND. tx_valid=1 with tx_data=START_BYTE in cycle N+1. busy=1 from N+1.
- Requests with req_ready=0 are ignored; they are not queued.
- Byte sequence, index 0..5:
  - MCT: START, M, C, T, chk, STOP
  - MD: START, M, D, req_data, chk, STOP
- Checksum: chk = (START_BYTE + STOP_BYTE + byte1 + byte2 + byte3) mod 256, 8-bit wrap, carries discarded. sum accumulates bytes 1..3 as each is accepted. Index 4 outputs sum.
- Handshake:
  - A byte transfers on the cycle where tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and index hold stable.
  - tx_valid never drops before acceptance.
- States: IDLE -> SEND -> (GAP if GAP_CYCLES>0) -> SEND ... -> IDLE.
  - SEND: accept with index<5 -> index+1. Then either next byte in the following cycle (GAP_CYCLES=0, tx_valid stays 1), or GAP with tx_valid=0 for exactly GAP_CYCLES cycles, then SEND.
  - SEND: accept with index==5 -> IDLE. tx_valid=0 and frame_done=1 in the next cycle. req_ready=1 in that same cycle, so a new request may be accepted there.
- Latency with GAP_CYCLES=0 and tx_ready held 1: 6 cycles from first tx_valid to STOP accept. frame_done comes 1 cycle later.
- tx_ready while tx_valid=0 is ignored.
- Mid-frame rst: frame aborts at once; no partial continuation after release. Partial frames are left for the decoder's resync-on-START.
- busy = (state != IDLE). req_ready = (state == IDLE). Both are registered or derived from registered state only.

Decomposition:
- Shared frame constants go in a common package/include used by both decoder and encoder: START/STOP/M/C/D/T, frame length 6, type encodings, checksum seed START+STOP.
- Single module. Byte selection is a case on index. No sub-module is warranted.

Test Plan:
- MCT, tx_ready=1 constant -> tx bytes AA 4D 43 54 E3 55 on 6 consecutive cycles, then frame_done pulse 1 cycle.
- MD with req_data=8'h10 -> AA 4D 44 10 A0 55. With req_data=8'hFF -> AA 4D 44 FF 8F 55 (checksum wrap).
- MD with tx_ready toggled randomly (including 3-cycle stalls on the checksum byte) -> same byte sequence; tx_data stable while stalled; no duplicate or skipped bytes.
- req_valid held high while busy with changing req_data -> current frame unaffected. Next frame starts only in the frame_done cycle and uses data sampled then.
- GAP_CYCLES=2 -> exactly 2 cycles of tx_valid=0 between each accepted byte and the next. Total from first valid to STOP accept = 16 cycles with tx_ready=1.
- rst asserted during index 3 -> tx_valid=0 immediately. After release: req_ready=1, busy=0, and the next request emits a complete frame starting with AA.

Source files
------------

// File: rtl/frame_encoder_pkg.sv
// Frame format shared by the command frame encoder and decoder:
// marker bytes, opcodes, frame length and checksum helpers.
package frame_encoder_pkg;

    localparam logic [7:0] START_BYTE = 8'hAA;
    localparam logic [7:0] STOP_BYTE  = 8'h55;
    localparam logic [7:0] CHAR_M     = 8'd77;
    localparam logic [7:0] CHAR_C     = 8'd67;
    localparam logic [7:0] CHAR_D     = 8'd68;
    localparam logic [7:0] CHAR_T     = 8'd84;

    localparam int unsigned FRAME_LEN  = 6;
    localparam logic [2:0]  LAST_INDEX = 3'(FRAME_LEN - 1);
    localparam logic [7:0]  CHK_SEED   = START_BYTE + STOP_BYTE;

    typedef enum logic {
        REQ_MCT = 1'b0,
        REQ_MD  = 1'b1
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } enc_state_e;

    // Byte at position idx of a frame; sum is the running checksum.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input req_type_e  typ,
        input logic [7:0] data,
        input logic [7:0] sum
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = START_BYTE;
            3'd1:    b = CHAR_M;
            3'd2:    b = (typ == REQ_MD) ? CHAR_D : CHAR_C;
            3'd3:    b = (typ == REQ_MD) ? data : CHAR_T;
            3'd4:    b = sum;
            3'd5:    b = STOP_BYTE;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/frame_encoder.sv
// Command frame encoder: turns a host request into a 6-byte frame and
// streams it to the UART transmitter over a valid/ready handshake.
module frame_encoder
    import frame_encoder_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_type,
    input  logic [7:0] req_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    enc_state_e    state_q, state_d;
    logic [2:0]    index_q, index_d;
    logic [7:0]    sum_q, sum_d;
    req_type_e     type_q, type_d;
    logic [7:0]    data_q, data_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    cur_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            index_q      <= 3'd0;
            sum_q        <= CHK_SEED;
            type_q       <= REQ_MCT;
            data_q       <= 8'h00;
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            sum_q        <= sum_d;
            type_q       <= type_d;
            data_q       <= data_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cur_byte = frame_byte(index_q, type_q, data_q, sum_q);

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        sum_d        = sum_q;
        type_d       = type_q;
        data_d       = data_q;
        gap_cnt_d    = gap_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    type_d  = req_type_e'(req_type);
                    data_d  = req_data;
                    index_d = 3'd0;
                    sum_d   = CHK_SEED;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (index_q == LAST_INDEX) begin
                        state_d      = ST_IDLE;
                        index_d      = 3'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        index_d = index_q + 3'd1;
                        // Header, opcode and argument feed the checksum as they leave.
                        if (index_q >= 3'd1 && index_q <= 3'd3) begin
                            sum_d = sum_q + cur_byte;
                        end
                        if (GAP_CYCLES > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_valid   = (state_q == ST_SEND);
    assign tx_data    = tx_valid ? cur_byte : 8'h00;
    assign busy       = (state_q != ST_IDLE);
    assign req_ready  = (state_q == ST_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_encoder.sv
// Self-checking bench for frame_encoder: table vectors, random frames against
// a byte-list reference model, stall/hold/gap/reset corner sequences.
module tb_frame_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0, req_type = 1'b0, tx_ready = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, tx_valid, busy, frame_done;
    logic [7:0] tx_data;

    logic       g_req_valid = 1'b0, g_req_type = 1'b0, g_tx_ready = 1'b0;
    logic [7:0] g_req_data = 8'h00;
    logic       g_req_ready, g_tx_valid, g_busy, g_frame_done;
    logic [7:0] g_tx_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frame_encoder #(.GAP_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_data(req_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    frame_encoder #(.GAP_CYCLES(2)) u_gap (
        .clk(clk), .rst(rst),
        .req_valid(g_req_valid), .req_ready(g_req_ready),
        .req_type(g_req_type), .req_data(g_req_data),
        .tx_data(g_tx_data), .tx_valid(g_tx_valid), .tx_ready(g_tx_ready),
        .busy(g_busy), .frame_done(g_frame_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list the six frame bytes, checksum as a plain mod-256 sum.
    function automatic logic [47:0] model_frame(input bit typ, input logic [7:0] data);
        int b[6];
        logic [47:0] f;
        b[0] = 'hAA;
        b[1] = 77;
        b[2] = typ ? 68 : 67;
        b[3] = typ ? int'(data) : 84;
        b[5] = 'h55;
        b[4] = (b[0] + b[5] + b[1] + b[2] + b[3]) % 256;
        f = '0;
        for (int i = 0; i < 6; i++) f[47-8*i -: 8] = 8'(b[i]);
        return f;
    endfunction

    task automatic start_req(input bit typ, input logic [7:0] data);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_type  = typ;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    // Entered one step after the accepting edge. mode 0: ready always,
    // 1: random ready, 2: random ready with a 3-cycle stall on the checksum.
    task automatic collect(input string name, input logic [47:0] exp, input int mode,
                           input bit hold, input logic [7:0] nxt);
        logic [7:0] got[$];
        logic [7:0] prev;
        bit stalled, rdy, last;
        int cycles, stall3;
        got = {};
        stalled = 0; last = 0; cycles = 0; stall3 = 0; prev = 8'h00;
        check({name, "_start_valid"}, {31'd0, tx_valid}, 32'd1);
        check({name, "_start_byte"}, {24'd0, tx_data}, 32'h0000_00AA);
        while (!last && cycles < 300) begin
            if (tx_valid && stalled) check({name, "_stall_hold"}, {24'd0, tx_data}, {24'd0, prev});
            if (frame_done) check({name, "_early_done"}, {31'd0, frame_done}, 32'd0);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 2 && tx_valid && got.size() == 4 && stall3 < 3) begin
                rdy = 1'b0;
                stall3++;
            end else rdy = 1'($urandom_range(0, 1));
            tx_ready = rdy;
            if (hold) req_data = 8'($urandom);
            if (tx_valid && rdy) begin
                got.push_back(tx_data);
                if (got.size() == 6) last = 1;
            end
            stalled = tx_valid && !rdy;
            prev = tx_data;
            tick();
            cycles++;
        end
        tx_ready = 1'b0;
        check({name, "_nbytes"}, got.size(), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check($sformatf("%s_byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp[47-8*i -: 8]});
        if (mode == 0) check({name, "_latency"}, cycles, 32'd6);
        check({name, "_done"}, {31'd0, frame_done}, 32'd1);
        check({name, "_idle_valid"}, {31'd0, tx_valid}, 32'd0);
        check({name, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        $display("[TB] frame %s: %0d bytes in %0d cycles", name, got.size(), cycles);
        if (hold) begin
            req_data = nxt;
            tick();
            req_valid = 1'b0;
        end else begin
            tick();
            check({name, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
        end
    endtask

    typedef struct {
        bit          typ;
        logic [7:0]  data;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b0, 8'h00, 48'hAA4D_4354_E355};
        vecs[1] = '{1'b1, 8'h10, 48'hAA4D_4410_A055};
        vecs[2] = '{1'b1, 8'hFF, 48'hAA4D_44FF_8F55};
        vecs[3] = '{1'b1, 8'h00, 48'hAA4D_4400_9055};
        vecs[4] = '{1'b1, 8'h80, 48'hAA4D_4480_1055};

        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_gap_ready", {31'd0, g_req_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            start_req(vecs[i].typ, vecs[i].data);
            check("busy_on", {31'd0, busy}, 32'd1);
            collect($sformatf("vec%0d", i), vecs[i].exp, 0, 1'b0, 8'h00);
        end

        collect_stall: begin
            start_req(1'b1, 8'h10);
            collect("md_stall", 48'hAA4D_4410_A055, 2, 1'b0, 8'h00);
        end

        for (int i = 0; i < 12; i++) begin
            bit t;
            logic [7:0] d;
            int m;
            t = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            m = int'($urandom_range(1, 2));
            start_req(t, d);
            collect($sformatf("rnd%0d", i), model_frame(t, d), m, 1'b0, 8'h00);
        end

        // Request held high while busy: only the done-cycle data starts frame 2.
        req_valid = 1'b1;
        req_type  = 1'b1;
        req_data  = 8'h3C;
        tick();
        collect("hold_a", model_frame(1'b1, 8'h3C), 0, 1'b1, 8'hC7);
        collect("hold_b", model_frame(1'b1, 8'hC7), 1, 1'b0, 8'h00);

        // Inter-byte gap of 2 cycles on the second instance.
        begin
            int cyc, nb, gapc;
            logic [47:0] ge;
            ge = model_frame(1'b0, 8'h00);
            g_req_valid = 1'b1;
            g_req_type  = 1'b0;
            tick();
            g_req_valid = 1'b0;
            g_tx_ready  = 1'b1;
            cyc = 0; nb = 0; gapc = 0;
            while (nb < 6 && cyc < 100) begin
                if (g_tx_valid) begin
                    if (nb > 0) check($sformatf("gap_len%0d", nb), gapc, 32'd2);
                    check($sformatf("gap_byte%0d", nb), {24'd0, g_tx_data}, {24'd0, ge[47-8*nb -: 8]});
                    nb++;
                    gapc = 0;
                end else gapc++;
                tick();
                cyc++;
            end
            g_tx_ready = 1'b0;
            check("gap_total", cyc, 32'd16);
            check("gap_done", {31'd0, g_frame_done}, 32'd1);
            $display("[TB] gap frame: %0d bytes in %0d cycles", nb, cyc);
        end

        // Reset while index 3 is on the bus.
        start_req(1'b1, 8'h5A);
        tx_ready = 1'b1;
        tick();
        tick();
        tick();
        tx_ready = 1'b0;
        check("rst_mid_byte3", {24'd0, tx_data}, 32'h0000_005A);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        check("rst_rel_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rel_busy", {31'd0, busy}, 32'd0);
        check("rst_rel_valid", {31'd0, tx_valid}, 32'd0);
        start_req(1'b0, 8'h00);
        collect("after_rst", 48'hAA4D_4354_E355, 0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
